// File: rtl/htif_burst_bridge.sv
// Host byte-stream to bus-master bridge: PING, single/burst word READ/WRITE,
// and an internal control register that drives per-core reset lines.
module htif_burst_bridge #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned N_CORES   = 1,
  parameter logic [63:0] CTRL_ADDR = 64'hFFFF_FFFC
) (
  input  logic               clock,
  input  logic               reset,
  output logic               rx_ready,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               bus_req_ready,
  output logic               bus_req_read,
  output logic               bus_req_write,
  output logic [AW-1:0]      bus_req_address,
  output logic [DW-1:0]      bus_req_data,
  input  logic               bus_res_valid,
  input  logic [DW-1:0]      bus_res_data,
  output logic [N_CORES-1:0] core_reset,
  output logic [3:0]         state
);

  localparam int unsigned BB = DW / 8;
  localparam int unsigned AB = AW / 8;
  localparam int unsigned CW = 8;
  localparam logic [AW-1:0] ALIGN_MASK = AW'(BB - 1);
  localparam logic [AW-1:0] CTRL_W     = AW'(CTRL_ADDR) & ~ALIGN_MASK;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ADDR  = 4'd1,
    LEN   = 4'd2,
    WDATA = 4'd3,
    WREQ  = 4'd4,
    RREQ  = 4'd5,
    RWAIT = 4'd6,
    RSEND = 4'd7,
    REPLY = 4'd8
  } state_t;

  state_t               state_q, state_n;
  logic [AW-1:0]        addr_q, addr_n;
  logic [DW-1:0]        data_q, data_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [7:0]           words_q, words_n;
  logic                 op_write_q, op_write_n;
  logic                 rx_ready_q, rx_ready_n;
  logic                 tx_valid_q, tx_valid_n;
  logic [7:0]           tx_data_q, tx_data_n;
  logic                 req_read_q, req_read_n;
  logic                 req_write_q, req_write_n;
  logic [N_CORES-1:0]   core_reset_q, core_reset_n;

  logic                 rx_fire;
  logic [AW-1:0]        addr_inc;
  logic [AW-1:0]        addr_aligned;
  logic [DW-1:0]        data_shift;

  assign rx_fire      = rx_valid & rx_ready_q;
  assign addr_inc     = addr_q + AW'(BB);
  assign addr_aligned = addr_q & ~ALIGN_MASK;
  assign data_shift   = data_q >> 8;

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      words_q      <= '0;
      op_write_q   <= 1'b0;
      rx_ready_q   <= 1'b1;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      req_read_q   <= 1'b0;
      req_write_q  <= 1'b0;
      core_reset_q <= '1;
    end else begin
      state_q      <= state_n;
      addr_q       <= addr_n;
      data_q       <= data_n;
      cnt_q        <= cnt_n;
      words_q      <= words_n;
      op_write_q   <= op_write_n;
      rx_ready_q   <= rx_ready_n;
      tx_valid_q   <= tx_valid_n;
      tx_data_q    <= tx_data_n;
      req_read_q   <= req_read_n;
      req_write_q  <= req_write_n;
      core_reset_q <= core_reset_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state_q;
    addr_n       = addr_q;
    data_n       = data_q;
    cnt_n        = cnt_q;
    words_n      = words_q;
    op_write_n   = op_write_q;
    tx_valid_n   = tx_valid_q;
    tx_data_n    = tx_data_q;
    req_read_n   = req_read_q;
    req_write_n  = req_write_q;
    core_reset_n = core_reset_q;

    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          case (rx_data[7:6])
            2'b00: begin
              tx_valid_n = 1'b1;
              tx_data_n  = 8'hA5;
              state_n    = REPLY;
            end
            2'b11: begin
              tx_valid_n = 1'b1;
              tx_data_n  = 8'hEE;
              state_n    = REPLY;
            end
            default: begin
              op_write_n = (rx_data[7:6] == 2'b01);
              cnt_n      = '0;
              state_n    = ADDR;
            end
          endcase
        end
      end
      ADDR: begin
        if (rx_fire) begin
          addr_n = (addr_q >> 8) | (AW'(rx_data) << (AW - 8));
          if (cnt_q == CW'(AB - 1)) begin
            cnt_n   = '0;
            state_n = LEN;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
      end
      LEN: begin
        if (rx_fire) begin
          words_n = rx_data;
          addr_n  = addr_aligned;
          cnt_n   = '0;
          if (op_write_q) begin
            state_n = WDATA;
          end else begin
            req_read_n = (addr_aligned != CTRL_W);
            state_n    = RREQ;
          end
        end
      end
      WDATA: begin
        if (rx_fire) begin
          data_n = data_shift | (DW'(rx_data) << (DW - 8));
          if (cnt_q == CW'(BB - 1)) begin
            cnt_n       = '0;
            req_write_n = (addr_q != CTRL_W);
            state_n     = WREQ;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
      end
      WREQ: begin
        // No request raised means this word targets the control register
        if (!req_write_q || bus_req_ready) begin
          if (!req_write_q) core_reset_n = data_q[N_CORES-1:0];
          req_write_n = 1'b0;
          if (words_q == 8'd0) begin
            tx_valid_n = 1'b1;
            tx_data_n  = 8'h06;
            state_n    = REPLY;
          end else begin
            words_n = words_q - 8'd1;
            addr_n  = addr_inc;
            state_n = WDATA;
          end
        end
      end
      RREQ: begin
        if (!req_read_q) begin
          data_n     = DW'(core_reset_q);
          tx_valid_n = 1'b1;
          tx_data_n  = 8'(core_reset_q);
          cnt_n      = '0;
          state_n    = RSEND;
        end else if (bus_req_ready) begin
          req_read_n = 1'b0;
          state_n    = RWAIT;
        end
      end
      RWAIT: begin
        if (bus_res_valid) begin
          data_n     = bus_res_data;
          tx_valid_n = 1'b1;
          tx_data_n  = bus_res_data[7:0];
          cnt_n      = '0;
          state_n    = RSEND;
        end
      end
      RSEND: begin
        if (tx_ready) begin
          if (cnt_q == CW'(BB - 1)) begin
            tx_valid_n = 1'b0;
            cnt_n      = '0;
            if (words_q == 8'd0) begin
              state_n = IDLE;
            end else begin
              words_n    = words_q - 8'd1;
              addr_n     = addr_inc;
              req_read_n = (addr_inc != CTRL_W);
              state_n    = RREQ;
            end
          end else begin
            cnt_n     = cnt_q + CW'(1);
            data_n    = data_shift;
            tx_data_n = data_shift[7:0];
          end
        end
      end
      REPLY: begin
        if (tx_ready) begin
          tx_valid_n = 1'b0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    rx_ready_n = (state_n == IDLE) || (state_n == ADDR) ||
                 (state_n == LEN)  || (state_n == WDATA);
  end

  assign rx_ready        = rx_ready_q;
  assign tx_valid        = tx_valid_q;
  assign tx_data         = tx_data_q;
  assign bus_req_read    = req_read_q;
  assign bus_req_write   = req_write_q;
  assign bus_req_address = addr_q;
  assign bus_req_data    = data_q;
  assign core_reset      = core_reset_q;
  assign state           = state_q;

endmodule

// File: doc/htif_burst_bridge.md
Name: htif_burst_bridge

Overview:
- Host-to-SoC bridge: parses a byte-stream command protocol from the host link and acts as bus master for single and burst word transfers.
- Owns a built-in control register that drives per-core reset lines.
- Successor to the fixed 32-bit, single-core host glue: data width, address width, core count and control address are parametrised.
- Adds burst transfers with address auto-increment and read-back of the control register.

Parameters:
- DW, 32, bus data width in bits; multiple of 8, 8..64.
- AW, 32, bus address width in bits; multiple of 8.
- N_CORES, 1, number of core_reset outputs; must be ≤ DW.
- CTRL_ADDR, 'hFFFF_FFFC, word address of the control register (truncated to AW).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- rx_ready  out  1  bridge accepts a host byte.
- rx_valid  in  1  host byte present.
- rx_data  in  8  host byte.
- tx_ready  in  1  host accepts a byte.
- tx_valid  out  1  byte to host present.
- tx_data  out  8  byte to host.
- bus_req_ready  in  1  bus accepts a request.
- bus_req_read  out  1  read request.
- bus_req_write  out  1  write request.
- bus_req_address  out  AW  request address.
- bus_req_data  out  DW  write data.
- bus_res_valid  in  1  read data valid.
- bus_res_data  in  DW  read data.
- core_reset  out  N_CORES  per-core reset, 1 = held in reset.
- state  out  4  FSM state encoding, debug only.

Behaviour:
Reset values:
- state=IDLE, rx_ready=1, tx_valid=0, tx_data=0.
- bus_req_read=0, bus_req_write=0, address and data regs 0.
- core_reset all ones.

Protocol (multi-byte fields little-endian):
- Command byte: bits[7:6] select the opcode; bits[5:0] are ignored.
- Opcode 00 PING: reply 0xA5.
- Opcode 11: reply 0xEE and return to IDLE.
- Opcodes 01 WRITE and 10 READ: command byte is followed by AW/8 address bytes, then one length byte L; transfer count = L+1 words (1..256).
- WRITE: followed by (L+1)*DW/8 data bytes.
- Address low log2(DW/8) bits are forced to 0 (word aligned).
- Address advances by DW/8 per word, modulo 2^AW (wraps silently).

FSM states:
- IDLE, ADDR, LEN, WDATA, WREQ, RREQ, RWAIT, RSEND, REPLY.
- rx_ready=1 only in IDLE, ADDR, LEN and WDATA. Each rx byte is consumed on rx_valid&rx_ready.
- WDATA: assemble DW/8 bytes, then go to WREQ.
- WREQ: hold bus_req_write, address and data until bus_req_ready, then next word (WDATA) or REPLY 0x06 after the last word.
- RREQ: hold bus_req_read until bus_req_ready, then RWAIT.
- RWAIT: capture bus_res_data on bus_res_valid, then RSEND.
- RSEND: emit DW/8 bytes LSB first, then RREQ for the next word or IDLE after the last word. A read burst has no trailing ack.
- REPLY: present the reply byte, then IDLE.

Handshakes:
- Bus request may be accepted in the cycle it is first asserted; req is deasserted the cycle after acceptance.
- At most one read outstanding.
- bus_res_valid in any state other than RWAIT is ignored.
- Zero-wait response: bus_res_valid is allowed the cycle after acceptance.
- tx_valid/tx_data are held stable until tx_ready; a byte transfers on tx_valid&tx_ready.

Control register:
- Write to CTRL_ADDR: never issued on the bus. core_reset <= data[N_CORES-1:0] and the burst continues in the next cycle.
- Read from CTRL_ADDR: never issued on the bus. Returns core_reset zero-extended to DW, with no bus wait.
- A burst crossing CTRL_ADDR intercepts only that word.

Boundaries:
- L=0 means exactly 1 word. L=255 means 256 words.
- Async reset mid-burst: aborts immediately to reset values (core_reset returns to all ones) and drops partial words.
- After reset, the host restarts with a fresh command byte.
- rx bytes are not accepted during bus or tx phases; backpressure via rx_ready=0.

Test Plan:
- Ping: rx 0x00 → tx 0xA5, no bus activity.
- Invalid opcode: rx 0xC0 → tx 0xEE, no bus activity.
- Single write, DW=32:
  - Stimulus: rx 40, 00 10 00 00, 00, 78 56 34 12.
  - Bus sees 1 write, addr 0x1000, data 0x12345678. bus_req_ready held low 3 cycles; request stays stable until accepted.
  - Then tx 0x06.
- Burst read:
  - Stimulus: rx 80, 08 00 00 00, 01. Responses 0xAABBCCDD then 0x11223344, with tx_ready toggling.
  - Reads at 0x8 then 0xC. tx DD CC BB AA 44 33 22 11. No ack byte.
- Control register, N_CORES=2:
  - Write 0x2 to FFFF_FFFC: no bus request; core_reset goes 11→10; tx 0x06.
  - Read FFFF_FFFC: tx 02 00 00 00.
- Wrap and reset:
  - Burst write L=1 from FFFF_FFF8: first word goes to the bus; second word intercepted at FFFF_FFFC.
  - Repeat with reset asserted mid-WDATA: outputs go to reset values asynchronously and the next PING replies 0xA5.
